// File: rtl/pc_unit_pkg.sv
// Shared encodings and constants for the program-counter unit.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PC_BOOT   = 2'd0,
    PC_RUN    = 2'd1,
    PC_HALTED = 2'd2,
    PC_FAULT  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: priority select, target arithmetic and
// JR alignment check. Stall/halt handling lives in the caller.
module pc_next_mux
  import pc_unit_pkg::*;
(
  input  logic [31:0] inst_address_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        jr_fault
);

  npc_sel_e sel;

  // Priority select: JR over J over taken branch over sequential.
  always_comb begin
    sel = NPC_SEQ;
    if (jump_reg)          sel = NPC_JR;
    else if (jump)         sel = NPC_J;
    else if (branch_taken) sel = NPC_BR;
  end

  // Target arithmetic for the selected source; branch sum wraps mod 2^32.
  always_comb begin
    next_pc  = inst_address_plus4;
    jr_fault = 1'b0;
    case (sel)
      NPC_SEQ: next_pc = inst_address_plus4;
      NPC_BR:  next_pc = inst_address_plus4 + (branch_offset << 2);
      NPC_J:   next_pc = {inst_address_plus4[31:28], jump_index, 2'b00};
      NPC_JR: begin
        next_pc  = reg_target;
        jr_fault = (reg_target[1:0] != 2'b00);
      end
      default: next_pc = inst_address_plus4;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register, run/halt/fault sequencing and retired-instruction
// counter for the single-cycle MIPS datapath.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_address_plus4,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jump_reg,
  input  logic [31:0]      reg_target,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  output logic [31:0]      inst_address,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [31:0]      fault_addr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A misaligned reset vector is a parameter error caught at elaboration.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("pc_unit: RESET_VECTOR %h is not word aligned", RESET_VECTOR);
  end

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             misaligned_q, misaligned_d;
  logic [31:0]      fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] next_pc;
  logic        jr_fault;

  pc_next_mux u_next_mux (
    .inst_address_plus4 (inst_address_plus4),
    .branch_taken       (branch_taken),
    .branch_offset      (branch_offset),
    .jump               (jump),
    .jump_index         (jump_index),
    .jump_reg           (jump_reg),
    .reg_target         (reg_target),
    .next_pc            (next_pc),
    .jr_fault           (jr_fault)
  );

  // State, PC, fault capture and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PC_BOOT;
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
      fault_addr_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      fault_addr_q <= fault_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and register updates; in RUN, stall masks everything, then halt,
  // then a misaligned JR, then the mux's chosen target.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    fault_addr_d = fault_addr_q;
    cnt_d        = cnt_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = PC_HALTED;
            cnt_d   = cnt_q + CNT_ONE;
          end else if (jr_fault) begin
            state_d      = PC_FAULT;
            misaligned_d = 1'b1;
            fault_addr_d = reg_target;
          end else begin
            pc_d  = next_pc;
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      PC_HALTED: begin
        if (resume) begin
          state_d = PC_RUN;
          pc_d    = inst_address_plus4;
        end
      end
      PC_FAULT: misaligned_d = 1'b1;
      default:  state_d = PC_BOOT;
    endcase
  end

  assign inst_address = pc_q;
  assign pc_valid     = (state_q == PC_RUN);
  assign misaligned   = misaligned_q;
  assign fault_addr   = fault_addr_q;
  assign state        = state_q;
  assign inst_count   = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with PC+4 looped back from the PC.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_address_plus4;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [31:0] inst_address;
  logic        pc_valid;
  logic        misaligned;
  logic [31:0] fault_addr;
  logic [1:0]  state;
  logic [31:0] inst_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .inst_address_plus4 (inst_address_plus4),
    .branch_taken       (branch_taken),
    .branch_offset      (branch_offset),
    .jump               (jump),
    .jump_index         (jump_index),
    .jump_reg           (jump_reg),
    .reg_target         (reg_target),
    .stall              (stall),
    .halt               (halt),
    .resume             (resume),
    .inst_address       (inst_address),
    .pc_valid           (pc_valid),
    .misaligned         (misaligned),
    .fault_addr         (fault_addr),
    .state              (state),
    .inst_count         (inst_count)
  );

  always #5 clk = ~clk;

  assign inst_address_plus4 = inst_address + 32'd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_run(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_pc"}, inst_address, pc);
    chk({tag, "_cnt"}, inst_count, cnt);
  endtask

  task automatic clear_inputs();
    branch_taken  = 1'b0;
    branch_offset = '0;
    jump          = 1'b0;
    jump_index    = '0;
    jump_reg      = 1'b0;
    reg_target    = '0;
    stall         = 1'b0;
    halt          = 1'b0;
    resume        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset values
    #12;
    chk("rst_pc", inst_address, 32'h0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_faddr", fault_addr, 32'h0);
    chk("rst_cnt", inst_count, 32'd0);

    // Boot cycle then sequential fetch
    rst_n = 1'b1;
    #1;
    chk("boot_state", {30'd0, state}, 32'd0);
    chk("boot_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_valid", {31'd0, pc_valid}, 32'd1);
    chk_run("seq0", 32'h0, 32'd0);
    tick(); chk_run("seq1", 32'h4, 32'd1);
    tick(); chk_run("seq2", 32'h8, 32'd2);
    tick(); chk_run("seq3", 32'hC, 32'd3);
    tick(); chk_run("seq4", 32'h10, 32'd4);

    // Backward branch: 0x14 + (-4 << 2) = 0x04
    branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFC;
    tick(); chk_run("branch_back", 32'h4, 32'd5);
    clear_inputs();

    // JR to 0x0040_0000, then J with index 0x100 -> 0x0000_0400
    jump_reg = 1'b1; reg_target = 32'h0040_0000;
    tick(); chk_run("jr_aligned", 32'h0040_0000, 32'd6);
    clear_inputs();
    jump = 1'b1; jump_index = 26'h0000100;
    tick(); chk_run("jump", 32'h0000_0400, 32'd7);
    clear_inputs();

    // Jump and branch together: jump to 0x20 wins over branch to 0x414
    jump = 1'b1; jump_index = 26'h8; branch_taken = 1'b1; branch_offset = 32'd4;
    tick(); chk_run("jump_over_br", 32'h20, 32'd8);
    clear_inputs();

    // Stall with jump (and halt) pending: everything holds for 3 cycles
    stall = 1'b1; jump = 1'b1; jump_index = 26'hC; halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_run("stall", 32'h20, 32'd8);
      chk("stall_state", {30'd0, state}, 32'd1);
    end
    stall = 1'b0; halt = 1'b0;
    tick(); chk_run("post_stall_jump", 32'h30, 32'd9);
    clear_inputs();

    // Halt at 0x30, inputs other than resume ignored while halted
    halt = 1'b1;
    tick();
    chk("halt_state", {30'd0, state}, 32'd2);
    chk("halt_valid", {31'd0, pc_valid}, 32'd0);
    chk_run("halt", 32'h30, 32'd10);
    clear_inputs();
    jump = 1'b1; jump_index = 26'h40; halt = 1'b1; jump_reg = 1'b1; reg_target = 32'h3;
    for (int i = 0; i < 5; i++) tick();
    chk("halted_hold_state", {30'd0, state}, 32'd2);
    chk_run("halted_hold", 32'h30, 32'd10);
    clear_inputs();
    resume = 1'b1;
    tick();
    chk("resume_state", {30'd0, state}, 32'd1);
    chk_run("resume", 32'h34, 32'd10);
    clear_inputs();

    // Misaligned JR -> FAULT, PC and count hold
    jump_reg = 1'b1; reg_target = 32'h0000_0102;
    tick();
    chk("fault_state", {30'd0, state}, 32'd3);
    chk("fault_mis", {31'd0, misaligned}, 32'd1);
    chk("fault_addr", fault_addr, 32'h102);
    chk("fault_valid", {31'd0, pc_valid}, 32'd0);
    chk_run("fault", 32'h34, 32'd10);
    reg_target = 32'h200; resume = 1'b1; jump = 1'b1; jump_index = 26'h7;
    tick(); tick();
    chk("fault_sticky_state", {30'd0, state}, 32'd3);
    chk("fault_sticky_addr", fault_addr, 32'h102);
    chk_run("fault_sticky", 32'h34, 32'd10);
    clear_inputs();

    // Reset pulse clears the fault
    rst_n = 1'b0;
    #1;
    chk("fault_rst_state", {30'd0, state}, 32'd0);
    chk("fault_rst_mis", {31'd0, misaligned}, 32'd0);
    chk("fault_rst_faddr", fault_addr, 32'h0);
    chk_run("fault_rst", 32'h0, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("reboot_state", {30'd0, state}, 32'd1);

    // Async reset between edges while PC = 0x100
    jump_reg = 1'b1; reg_target = 32'h100;
    tick(); chk_run("to_0x100", 32'h100, 32'd1);
    clear_inputs();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk_run("async_rst", 32'h0, 32'd0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
